// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory address and
// loads the IF/ID register, applying branch/jump redirects, hazard stall/flush and STOP halt.
module if_stage #(
  parameter int unsigned              DATA_WIDTH = 16,
  parameter int unsigned              ADDR_WIDTH = 8,
  parameter int unsigned              IMM8_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0]    RESET_PC   = 8'h00,
  parameter logic [DATA_WIDTH-1:0]    NOP_INSTR  = 16'h0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_IF_ID_i,
  input  logic                  flush_IF_ID_i,
  input  logic                  JumpD_i,
  input  logic [IMM8_WIDTH-1:0] jumpAddr_i,
  input  logic                  PCSrcE_i,
  input  logic [ADDR_WIDTH-1:0] branchAddrE_i,
  input  logic                  StopD_i,
  output logic [ADDR_WIDTH-1:0] im_addr_o,
  input  logic [DATA_WIDTH-1:0] im_rD_i,
  output logic [ADDR_WIDTH-1:0] PCD_o,
  output logic [DATA_WIDTH-1:0] instructionD_o,
  output logic                  validD_o,
  output logic                  halted_o,
  output logic [15:0]           fetch_cnt_o
);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] pcd_q, pcd_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic                  valid_q, valid_d;
  logic [15:0]           cnt_q, cnt_d;
  logic                  halt_go;

  // A STOP only halts when it is a real instruction that is actually leaving decode
  // and no older taken branch is about to squash it.
  assign halt_go = (state_q == RUN) && StopD_i && valid_q && !stall_IF_ID_i && !PCSrcE_i;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pcd_d   = pcd_q;
    instr_d = instr_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;

    if ((state_q == HALT) || halt_go) begin
      state_d = HALT;
      pcd_d   = '0;
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (PCSrcE_i) begin
      pc_d    = branchAddrE_i;
      pcd_d   = '0;
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (stall_IF_ID_i) begin
      // Flush still squashes IF/ID while the PC holds.
      if (flush_IF_ID_i) begin
        pcd_d   = '0;
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
      end
    end else begin
      if (JumpD_i) begin
        pc_d = ADDR_WIDTH'(jumpAddr_i);
      end else begin
        pc_d = pc_q + ADDR_WIDTH'(1);
      end
      if (flush_IF_ID_i || JumpD_i) begin
        pcd_d   = '0;
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
      end else begin
        pcd_d   = pc_q;
        instr_d = im_rD_i;
        valid_d = 1'b1;
        if (cnt_q != 16'hFFFF) begin
          cnt_d = cnt_q + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      pcd_q   <= '0;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pcd_q   <= pcd_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign im_addr_o      = pc_q;
  assign PCD_o          = pcd_q;
  assign instructionD_o = instr_q;
  assign validD_o       = valid_q;
  assign halted_o       = (state_q == HALT);
  assign fetch_cnt_o    = cnt_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: memory stub returns 16'h1000+addr; a cycle-level model of the
// fetch rules is compared every negedge, plus hand-computed literal checks.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, flush, jump, pcsrc, stop;
  logic [7:0]  jump_addr, branch_addr;
  logic [7:0]  im_addr, pcd;
  logic [15:0] im_rd, instr, cnt;
  logic        valid, halted;

  int n_checks = 0;
  int n_fail   = 0;
  bit started  = 0;

  // model state
  logic [7:0]  m_pc = 8'h00, m_pcd = 8'h00;
  logic [15:0] m_instr = 16'h0000, m_cnt = 16'h0000;
  logic        m_valid = 1'b0, m_halted = 1'b0;

  always #5 clk = ~clk;

  assign im_rd = 16'h1000 + {8'h00, im_addr};

  if_stage dut (
    .clk            (clk),
    .rst            (rst),
    .stall_IF_ID_i  (stall),
    .flush_IF_ID_i  (flush),
    .JumpD_i        (jump),
    .jumpAddr_i     (jump_addr),
    .PCSrcE_i       (pcsrc),
    .branchAddrE_i  (branch_addr),
    .StopD_i        (stop),
    .im_addr_o      (im_addr),
    .im_rD_i        (im_rd),
    .PCD_o          (pcd),
    .instructionD_o (instr),
    .validD_o       (valid),
    .halted_o       (halted),
    .fetch_cnt_o    (cnt)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 0; flush = 0; jump = 0; pcsrc = 0; stop = 0;
  endtask

  // Model: what decode must hold and where fetch must point after each edge.
  always @(posedge clk) begin
    bit bubble, load, halt_now;
    logic [7:0] next_pc;
    started = 1;
    if (rst) begin
      m_pc = 8'h00; m_pcd = 8'h00; m_instr = 16'h0000;
      m_valid = 0; m_halted = 0; m_cnt = 16'h0000;
    end else begin
      halt_now = m_halted || (stop && m_valid && !stall && !pcsrc);
      // PC selection
      if (halt_now)      next_pc = m_pc;
      else if (pcsrc)    next_pc = branch_addr;
      else if (stall)    next_pc = m_pc;
      else if (jump)     next_pc = jump_addr;
      else               next_pc = m_pc + 8'd1;
      // decode register
      bubble = halt_now || pcsrc || flush || (!stall && jump);
      load   = !bubble && !stall;
      if (bubble) begin
        m_pcd = 8'h00; m_instr = 16'h0000; m_valid = 0;
      end else if (load) begin
        m_pcd = m_pc; m_instr = 16'h1000 + {8'h00, m_pc}; m_valid = 1;
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      end
      m_pc = next_pc;
      if (halt_now) m_halted = 1;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("im_addr", {8'h00, im_addr}, {8'h00, m_pc});
      chk("pcd",     {8'h00, pcd},     {8'h00, m_pcd});
      chk("instr",   instr,            m_instr);
      chk("valid",   {15'h0, valid},   {15'h0, m_valid});
      chk("halted",  {15'h0, halted},  {15'h0, m_halted});
      chk("cnt",     cnt,              m_cnt);
    end
  end

  initial begin
    rst = 1; jump_addr = 8'h00; branch_addr = 8'h00;
    idle();
    tick(); tick();
    rst = 0;

    // Straight-line fetch after reset
    tick(); tick(); tick();
    @(negedge clk);
    chk("lit_pcd_2",   {8'h00, pcd}, 16'h0002);
    chk("lit_instr_2", instr, 16'h1002);
    chk("lit_cnt_3",   cnt, 16'h0003);
    chk("lit_addr_3",  {8'h00, im_addr}, 16'h0003);

    // Wrap at 8'hFF
    jump = 1; jump_addr = 8'hFF; tick(); idle();
    tick();
    @(negedge clk);
    chk("lit_wrap_addr", {8'h00, im_addr}, 16'h0000);
    chk("lit_wrap_pcd",  {8'h00, pcd}, 16'h00FF);
    chk("lit_wrap_valid", {15'h0, valid}, 16'h0001);

    // Jump to 8'h40: one bubble
    jump = 1; jump_addr = 8'h40; tick(); idle();
    @(negedge clk);
    chk("lit_jmp_addr",  {8'h00, im_addr}, 16'h0040);
    chk("lit_jmp_valid", {15'h0, valid}, 16'h0000);
    tick();
    @(negedge clk);
    chk("lit_jmp_pcd",   {8'h00, pcd}, 16'h0040);

    // Plain stall, flush, stall+flush, jump held under stall
    stall = 1; tick(); tick(); idle();
    flush = 1; tick(); idle();
    tick();
    stall = 1; flush = 1; tick(); idle();
    tick();
    stall = 1; jump = 1; jump_addr = 8'h80; tick();
    stall = 0; tick(); idle();
    tick(); tick();

    // Stall and branch together: branch wins
    stall = 1; pcsrc = 1; branch_addr = 8'h20; tick(); idle();
    @(negedge clk);
    chk("lit_br_addr",  {8'h00, im_addr}, 16'h0020);
    chk("lit_br_instr", instr, 16'h0000);
    chk("lit_br_valid", {15'h0, valid}, 16'h0000);
    tick(); tick();

    // STOP under stall does not halt
    stall = 1; stop = 1; tick(); idle();
    tick();

    // STOP with simultaneous branch: no halt
    stop = 1; pcsrc = 1; branch_addr = 8'h30; tick(); idle();
    @(negedge clk);
    chk("lit_stopbr_halted", {15'h0, halted}, 16'h0000);
    chk("lit_stopbr_addr",   {8'h00, im_addr}, 16'h0030);

    // Bring PC 8'h05 into decode, then STOP
    pcsrc = 1; branch_addr = 8'h05; tick(); idle();
    tick();
    @(negedge clk);
    chk("lit_pcd_05", {8'h00, pcd}, 16'h0005);
    stop = 1; tick(); idle();
    @(negedge clk);
    chk("lit_halted",    {15'h0, halted}, 16'h0001);
    chk("lit_halt_addr", {8'h00, im_addr}, 16'h0006);
    for (int i = 0; i < 20; i++) begin
      jump = i[0]; pcsrc = i[1]; flush = i[2]; jump_addr = 8'h77; branch_addr = 8'h99;
      tick();
    end
    idle();
    @(negedge clk);
    chk("lit_frozen_addr",  {8'h00, im_addr}, 16'h0006);
    chk("lit_frozen_valid", {15'h0, valid}, 16'h0000);
    rst = 1; tick(); rst = 0;
    @(negedge clk);
    chk("lit_recover_addr",   {8'h00, im_addr}, 16'h0000);
    chk("lit_recover_halted", {15'h0, halted}, 16'h0000);

    // Counter saturation
    for (int i = 0; i < 65540; i++) tick();
    @(negedge clk);
    chk("lit_cnt_sat", cnt, 16'hFFFF);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
